// File: rtl/calc_pkg.sv
// Shared constants and types for the calculator display path.
// Holds the digit-index encoding used by the scan logic, the dash and blank
// patterns, and the active-low gfedcba segment table for hex digits 0-F.
package calc_pkg;

    // Scan position; the numeric value is also the anode bit index.
    typedef enum logic [1:0] {
        DIG_SUM   = 2'd0,
        DIG_CARRY = 2'd1,
        DIG_B     = 2'd2,
        DIG_A     = 2'd3
    } dig_t;

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Entry [n] is the pattern for hex digit n, listed from F down to 0.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage

// File: rtl/calc_display_if.sv
// Signal bundle between the adder datapath and the display driver.
//   load, clear          : capture strobe / invalidate (datapath -> driver)
//   A, B, SUM, carry_out : values to display             (datapath -> driver)
//   seg, an, dp          : active-low display pins        (driver -> board)
interface calc_display_if;
    logic       load;
    logic       clear;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] SUM;
    logic       carry_out;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    modport master (
        output load, clear, A, B, SUM, carry_out,
        input  seg, an, dp
    );

    modport slave (
        input  load, clear, A, B, SUM, carry_out,
        output seg, an, dp
    );
endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex-to-seven-segment decoder.
//   nibble : 4-bit value 0-F
//   seg    : active-low segments, seg[6:0] = g,f,e,d,c,b,a
module hex_to_seg7
    import calc_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = HEX_SEG[nibble];
    end

endmodule

// File: rtl/calc_display_driver.sv
// Four-digit multiplexed seven-segment driver for the calculator.
// Captures A, B, {carry_out, SUM} on load and scans them left to right as
// A, B, carry, SUM (hex) on a common-anode, active-low display.
//   clk   : system clock
//   reset : asynchronous, active-high reset
//   bus   : calc_display_if.slave (load/clear/operands in, seg/an/dp out)
module calc_display_driver
    import calc_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000
)
(
    input  logic           clk,
    input  logic           reset,
    calc_display_if.slave  bus
);

    localparam int unsigned        CNT_W    = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic             wrap;
    dig_t             idx;
    dig_t             idx_next;

    logic [3:0] a_q;
    logic [3:0] b_q;
    logic [3:0] s_q;
    logic       c_q;
    logic       valid;

    logic [3:0] nibble;
    logic [6:0] hex_seg;
    logic [6:0] seg_next;
    logic [3:0] an_next;
    logic [6:0] seg_q;
    logic [3:0] an_q;

    // Capture: clear wins over load and leaves the data regs untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            c_q   <= 1'b0;
            valid <= 1'b0;
        end else if (bus.clear) begin
            valid <= 1'b0;
        end else if (bus.load) begin
            a_q   <= bus.A;
            b_q   <= bus.B;
            s_q   <= bus.SUM;
            c_q   <= bus.carry_out;
            valid <= 1'b1;
        end
    end

    // Refresh counter; wrap marks the last cycle of the current digit.
    assign wrap = (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Scan state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= DIG_SUM;
        end else begin
            idx <= idx_next;
        end
    end

    // Scan next-state.
    always_comb begin
        idx_next = idx;
        if (wrap) begin
            unique case (idx)
                DIG_SUM:   idx_next = DIG_CARRY;
                DIG_CARRY: idx_next = DIG_B;
                DIG_B:     idx_next = DIG_A;
                DIG_A:     idx_next = DIG_SUM;
                default:   idx_next = DIG_SUM;
            endcase
        end
    end

    // Scan outputs: digit select and segment pattern for the current index.
    always_comb begin
        nibble = s_q;
        unique case (idx)
            DIG_SUM:   nibble = s_q;
            DIG_CARRY: nibble = {3'b000, c_q};
            DIG_B:     nibble = b_q;
            DIG_A:     nibble = a_q;
            default:   nibble = s_q;
        endcase
    end

    hex_to_seg7 u_hex (
        .nibble (nibble),
        .seg    (hex_seg)
    );

    always_comb begin
        an_next  = ~(4'b0001 << idx);
        seg_next = hex_seg;
        if (!valid) begin
            seg_next = SEG_DASH;
        end else if (idx == DIG_CARRY && !c_q) begin
            // A zero carry is leading-zero suppressed.
            seg_next = SEG_BLANK;
        end
    end

    // Registered pin drivers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_q  <= '1;
            seg_q <= '1;
        end else begin
            an_q  <= an_next;
            seg_q <= seg_next;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = 1'b1;

endmodule

// File: doc/calc_display_driver.md
Name: calc_display_driver

Overview:
- Output stage directly downstream of the 4-bit adder in the FPGA calculator.
- Captures operands A and B plus the adder result {carry_out, SUM} on a load strobe.
- Time-multiplexes them onto a 4-digit, common-anode, active-low seven-segment display.
- Digit order, left to right: digit3 = A, digit2 = B, digit1 = carry, digit0 = SUM, all in hex.

Parameters:
- REFRESH_DIV, 100000, clock cycles each digit stays lit; must be >= 2; counter width is $clog2(REFRESH_DIV).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- load  input  1  capture strobe; level-sensitive, samples every cycle it is high.
- clear  input  1  invalidates captured data; the display shows dashes.
- A  input  4  operand A, from the adder's A input.
- B  input  4  operand B.
- SUM  input  4  adder sum.
- carry_out  input  1  adder carry.
- seg  output  7  cathodes, active-low; seg[6:0] = g,f,e,d,c,b,a.
- an  output  4  anodes, active-low; an[3] is the leftmost digit.
- dp  output  1  decimal point, active-low; always 1 (off).

Behaviour:
- Single clock domain. Reset is asynchronous and active-high, applied to every flop.
- Values while reset is high:
  - refresh counter = 0, digit index = 0, valid = 0
  - captured regs (A_q, B_q, C_q, S_q) = 0
  - an = 4'b1111, seg = 7'b1111111, dp = 1
- Capture:
  - On a rising edge with load=1 and clear=0: A_q<=A, B_q<=B, C_q<=carry_out, S_q<=SUM, valid<=1.
  - clear=1: valid<=0 and captured regs are unchanged. clear has priority over a simultaneous load.
- Refresh:
  - Counter increments each cycle from 0 to REFRESH_DIV-1, then wraps to 0.
  - On the wrap cycle the digit index advances 0→1→2→3→0.
  - Index 3 wraps to 0 with no gap cycle.
- Output register (one cycle latency from index and captured regs):
  - an <= ~(4'b0001 << idx); exactly one bit low outside reset.
  - seg <= encoding of the selected digit.
  - First post-reset clock edge: an = 4'b1110, seg = dash.
- Digit selection:
  - idx0: S_q.
  - idx1: C_q. Shown as '1' when C_q=1; blank (7'b1111111) when C_q=0, as leading-zero suppression.
  - idx2: B_q.
  - idx3: A_q.
- When valid=0, every digit shows a dash (7'b0111111), including idx1.
- Hex encoding, gfedcba active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Boundary conditions:
  - Load mid-scan: the new value appears on the currently lit digit one cycle after the capture edge. The scan is not restarted.
  - Reset mid-scan: outputs go to their reset values immediately (asynchronously). The scan restarts at idx0.
  - load held high: display tracks the inputs with 2-cycle latency.
  - Inputs changing without load: no effect on outputs.

Decomposition:
- Shared package calc_pkg holds:
  - SEG_DASH, SEG_BLANK and the 16-entry hex segment constants
  - digit index encodings DIG_SUM=0, DIG_CARRY=1, DIG_B=2, DIG_A=3
- One combinational sub-module, hex_to_seg7: 4-bit nibble in, 7-bit active-low segments out.
- The top level holds the capture registers, refresh counter, index, mux and output register.

Test Plan:
- Reset, then release with REFRESH_DIV=4 → an steps 1110, 1101, 1011, 0111, 1110 every 4 cycles; seg=0111111 on every digit; dp=1 throughout.
- A=3, B=5, SUM=8, carry_out=0, pulse load → digit0 seg=0000000 ('8'), digit1 blank 1111111, digit2 0010010 ('5'), digit3 0110000 ('3').
- A=F, B=1, SUM=0, carry_out=1, pulse load → digit0 1000000 ('0'), digit1 1111001 ('1'), digit2 1111001, digit3 0001110 ('F').
- load and clear high in the same cycle → valid=0; all digits show dash; captured regs keep their prior values, so a subsequent clear-free load shows new data correctly.
- Assert reset while an=1011 mid-count → an=1111 and seg=1111111 within the same cycle (asynchronous); after release, the scan resumes at an=1110 with dashes.
- Change A, B, SUM without load for 20 cycles → seg/an pattern is identical to the prior captured display.
